// File: rtl/freq_counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// freq_counter_pkg : shared constants for the multi-channel frequency counter
// Rev 1.0
// ---------------------------------------------------------------------------
package freq_counter_pkg;

   // Active-high segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   // One extra bit so selections beyond the last channel are representable
   function automatic int ch_sel_width(input int num_ch);
      return $clog2(num_ch) + 1;
   endfunction

   localparam int NUM_CH_DEFAULT = 4;
   localparam int CH_SEL_W       = ch_sel_width(NUM_CH_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/seven_segment_hex.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_segment_hex : 4-bit nibble to active-high 7-segment code
// Rev 1.0
// ---------------------------------------------------------------------------
module seven_segment_hex
   import freq_counter_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_0;
      case (nibble)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multi_channel_frequency_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_channel_frequency_counter : gated edge counting on NUM_CH async inputs
// with a multiplexed hex 7-segment readout.  Rev 1.0
// ---------------------------------------------------------------------------
module multi_channel_frequency_counter
   import freq_counter_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int COUNT_W        = 16,
   parameter int PERIOD_W       = 12,
   parameter int DEFAULT_PERIOD = 1000,
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_W      = 10
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CH-1:0]                 signal,
   input  logic                              period_load,
   input  logic [PERIOD_W-1:0]               period,
   input  logic [ch_sel_width(NUM_CH)-1:0]   chan_sel,
   output logic [COUNT_W-1:0]                count_out,
   output logic                              overflow_out,
   output logic                              update,
   output logic [6:0]                        segments,
   output logic [NUM_DIGITS-1:0]             digit
);

   localparam int                 SEL_W     = ch_sel_width(NUM_CH);
   localparam int                 DISP_W    = 4 * NUM_DIGITS;
   localparam int                 IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   logic [PERIOD_W-1:0]              period_reg;
   logic [PERIOD_W-1:0]              gate_cnt;
   logic                             gate_end;
   logic                             load_ok;
   logic [NUM_CH-1:0][COUNT_W-1:0]   result_bus;
   logic [NUM_CH-1:0]                ovf_bus;

   assign gate_end = (gate_cnt == '0);
   assign load_ok  = period_load && (period != '0);

   // A valid load restarts the gate and suppresses any coincident gate end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_reg <= PERIOD_W'(DEFAULT_PERIOD);
         gate_cnt   <= PERIOD_W'(DEFAULT_PERIOD - 1);
         update     <= 1'b0;
      end else begin
         update <= gate_end && !load_ok;
         if (load_ok) begin
            period_reg <= period;
            gate_cnt   <= period - 1'b1;
         end else if (gate_end) begin
            gate_cnt <= period_reg - 1'b1;
         end else begin
            gate_cnt <= gate_cnt - 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic               s1, s2, s3;
      logic               rise;
      logic [COUNT_W-1:0] count, count_next, result;
      logic               ovf;

      assign rise       = s2 & ~s3;
      assign count_next = (rise && (count != COUNT_MAX)) ? count + 1'b1 : count;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            count  <= '0;
            result <= '0;
            ovf    <= 1'b0;
         end else begin
            s1 <= signal[i];
            s2 <= s1;
            s3 <= s2;
            if (load_ok) begin
               count <= '0;
            end else if (gate_end) begin
               count  <= '0;
               result <= count_next;
               ovf    <= (count_next == COUNT_MAX);
            end else begin
               count <= count_next;
            end
         end
      end

      assign result_bus[i] = result;
      assign ovf_bus[i]    = ovf;
   end

   always_comb begin
      count_out    = '0;
      overflow_out = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (chan_sel == SEL_W'(i)) begin
            count_out    = result_bus[i];
            overflow_out = ovf_bus[i];
         end
      end
   end

   logic [REFRESH_W-1:0] refresh;
   logic [IDX_W-1:0]     digit_idx;
   logic [DISP_W-1:0]    disp;
   logic [3:0]           nibble;
   logic [6:0]           seg_code;

   if (COUNT_W >= DISP_W) begin : g_disp_trunc
      assign disp = count_out[DISP_W-1:0];
   end else begin : g_disp_pad
      assign disp = {{(DISP_W - COUNT_W){1'b0}}, count_out};
   end

   assign nibble = disp[{digit_idx, 2'b00} +: 4];
   assign digit  = NUM_DIGITS'(1) << digit_idx;

   seven_segment_hex u_seg (
      .nibble (nibble),
      .seg    (seg_code)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh   <= '0;
         digit_idx <= '0;
         segments  <= SEG_0;
      end else begin
         refresh <= refresh + 1'b1;
         if (refresh == '1) begin
            digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
         end
         segments <= seg_code;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_frequency_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multi_channel_frequency_counter : directed self-checking bench
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multi_channel_frequency_counter;

   logic        clk;
   logic        reset;
   logic [3:0]  sig;
   logic        period_load;
   logic [15:0] period;
   logic [freq_counter_pkg::CH_SEL_W-1:0] chan_sel;
   logic [15:0] count_out;
   logic        overflow_out, update;
   logic [6:0]  segments;
   logic [3:0]  digit;

   logic [1:0]  sat_sig;
   logic [1:0]  sat_sel;
   logic [3:0]  sat_count;
   logic        sat_ovf, sat_update;
   logic [6:0]  sat_segments;
   logic [1:0]  sat_digit;
   logic        sat_fast;

   int half[4];
   int hcnt[4];
   int cyc;
   int n_chk = 0;
   int n_fail = 0;

   multi_channel_frequency_counter #(
      .NUM_CH(4), .COUNT_W(16), .PERIOD_W(16), .DEFAULT_PERIOD(20),
      .NUM_DIGITS(4), .REFRESH_W(2)
   ) dut (
      .clk(clk), .reset(reset), .signal(sig), .period_load(period_load),
      .period(period), .chan_sel(chan_sel), .count_out(count_out),
      .overflow_out(overflow_out), .update(update), .segments(segments),
      .digit(digit)
   );

   multi_channel_frequency_counter #(
      .NUM_CH(2), .COUNT_W(4), .PERIOD_W(8), .DEFAULT_PERIOD(100),
      .NUM_DIGITS(2), .REFRESH_W(3)
   ) dut_sat (
      .clk(clk), .reset(reset), .signal(sat_sig), .period_load(1'b0),
      .period(8'd0), .chan_sel(sat_sel), .count_out(sat_count),
      .overflow_out(sat_ovf), .update(sat_update), .segments(sat_segments),
      .digit(sat_digit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Square-wave generators: half[i] clocks high, half[i] clocks low (0 = idle low)
   initial begin
      sig = '0;
      sat_sig = '0;
      for (int i = 0; i < 4; i++) hcnt[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (half[i] == 0) begin
               sig[i]  = 1'b0;
               hcnt[i] = 0;
            end else begin
               hcnt[i]++;
               if (hcnt[i] >= half[i]) begin
                  sig[i]  = ~sig[i];
                  hcnt[i] = 0;
               end
            end
         end
         sat_sig[1] = sat_fast ? ~sat_sig[1] : 1'b0;
      end
   end

   // Posedges since reset release, the reference for the display scan position
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         if (reset) cyc = 0;
         else       cyc++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int per;
      int h0, h1, h2, h3;
      int sel;
      int exp_cnt;
      bit exp_ovf;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [6:0] seg_ref(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;  default: return 7'b1110001;
      endcase
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic load(input int q);
      period      = 16'(q);
      period_load = 1'b1;
      @(negedge clk);
      period_load = 1'b0;
   endtask

   // Returns the number of negedges until the selected update is seen high
   task automatic wait_upd(input bit use_sat, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(use_sat ? sat_update : update) && n < budget);
      if (!(use_sat ? sat_update : update)) begin
         n_chk++;
         n_fail++;
         $display("FAIL update_timeout: no update within %0d clks", budget);
      end
   endtask

   initial begin
      int n;
      int idx, sidx;
      logic [15:0] shown;

      vecs[0] = '{100,  5, 0, 0,  0, 0, 10, 1'b0};
      vecs[1] = '{256,  2, 4, 8, 16, 0, 64, 1'b0};
      vecs[2] = '{256,  2, 4, 8, 16, 1, 32, 1'b0};
      vecs[3] = '{256,  2, 4, 8, 16, 2, 16, 1'b0};
      vecs[4] = '{256,  2, 4, 8, 16, 3,  8, 1'b0};
      vecs[5] = '{256,  2, 4, 8, 16, 5,  0, 1'b0};
      vecs[6] = '{60,   3, 1, 0,  0, 1, 30, 1'b0};
      vecs[7] = '{60,   3, 1, 0,  0, 0, 10, 1'b0};

      reset = 1'b1; period_load = 1'b0; period = '0; chan_sel = '0;
      sat_sel = '0; sat_fast = 1'b0;
      for (int i = 0; i < 4; i++) half[i] = 0;

      repeat (3) @(negedge clk);
      check("reset_update",   update,    0);
      check("reset_digit",    digit,     4'b0001);
      check("reset_segments", segments,  7'b0111111);
      check("reset_count",    count_out, 0);
      check("reset_ovf",      overflow_out, 0);
      check("reset_sat_count", sat_count, 0);
      reset = 1'b0;
      wait_upd(1'b0, 40, n);
      check("default_gate_len", n, 20);

      foreach (vecs[v]) begin
         half[0] = vecs[v].h0; half[1] = vecs[v].h1;
         half[2] = vecs[v].h2; half[3] = vecs[v].h3;
         chan_sel = 3'(vecs[v].sel);
         load(vecs[v].per);
         wait_upd(1'b0, vecs[v].per + 10, n);
         check("load_latency", n, vecs[v].per);
         wait_upd(1'b0, vecs[v].per + 10, n);
         check("gate_interval", n, vecs[v].per);
         check("vec_count", count_out, vecs[v].exp_cnt);
         check("vec_ovf", overflow_out, vecs[v].exp_ovf);
      end

      // Load landing exactly on a gate-end cycle must abort that gate
      wait_upd(1'b0, 70, n);
      check("steady_interval", n, 60);
      repeat (59) @(negedge clk);
      load(50);
      check("load_keeps_result", count_out, 10);
      wait_upd(1'b0, 70, n);
      check("coincident_load", n, 50);

      wait_upd(1'b0, 70, n);
      repeat (10) @(negedge clk);
      load(0);
      wait_upd(1'b0, 70, n);
      check("zero_period_ignored", n, 39);

      load(1);
      wait_upd(1'b0, 5, n);
      check("period1_latency", n, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("period1_continuous", update, 1);
      end

      // Saturation on the 4-bit instance
      sat_sel  = 2'd1;
      sat_fast = 1'b1;
      wait_upd(1'b1, 120, n);
      wait_upd(1'b1, 120, n);
      check("sat_count", sat_count, 15);
      check("sat_ovf",   sat_ovf,   1);
      sat_sel = 2'd0;
      #1;
      check("sat_idle_ch_count", sat_count, 0);
      check("sat_idle_ch_ovf",   sat_ovf,   0);
      sat_sel = 2'd2;
      #1;
      check("sat_out_of_range", {sat_ovf, sat_count}, 0);
      sat_sel  = 2'd1;
      sat_fast = 1'b0;
      wait_upd(1'b1, 120, n);
      wait_upd(1'b1, 120, n);
      check("sat_clear_count", sat_count, 0);
      check("sat_clear_ovf",   sat_ovf,   0);

      // Display scan of 16'h1A2F (6703 edges of a clk/2 input over 13406 clks)
      half[0] = 1; half[1] = 0; half[2] = 0; half[3] = 0;
      chan_sel = '0;
      load(13406);
      wait_upd(1'b0, 13500, n);
      check("long_latency", n, 13406);
      wait_upd(1'b0, 13500, n);
      check("long_interval", n, 13406);
      check("long_count", count_out, 16'h1A2F);
      check("long_ovf", overflow_out, 0);
      shown = 16'h1A2F;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         idx  = (cyc >> 2) & 3;
         sidx = ((cyc - 1) >> 2) & 3;
         check("scan_digit", digit, longint'(1) << idx);
         check("scan_segments", segments, seg_ref(shown[sidx*4 +: 4]));
      end

      // Asynchronous reset in the middle of a gate
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_count",    count_out, 0);
      check("async_update",   update,    0);
      check("async_digit",    digit,     4'b0001);
      check("async_segments", segments,  7'b0111111);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("partial_gate_discarded", count_out, 0);
      wait_upd(1'b0, 40, n);
      check("restart_gate_len", n, 15);
      wait_upd(1'b0, 40, n);
      check("restart_interval", n, 20);
      check("restart_count", count_out, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
